// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/rsp pair, and presents one decoded instruction at a time downstream.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pc;
  logic [31:0] rpc;

  assign rpc            = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = req_q;
  assign imem_addr      = pc;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      req_q      <= 1'b1;
      pc         <= RESET_PC;
      inst       <= NOP_INSTR;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redirect_valid)
            pc <= rpc;
          // an accepted request under a redirect is already stale
          if (imem_req_ready) begin
            state <= redirect_valid ? S_DROP : S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= rpc;
            if (imem_rsp_valid) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_DROP;
            end
          end else if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_DROP: begin
          if (redirect_valid)
            pc <= rpc;
          if (imem_rsp_valid) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || !stall) begin
            inst_valid <= 1'b0;
            state      <= S_REQ;
            req_q      <= 1'b1;
            if (redirect_valid)
              pc <= rpc;
          end
        end
        default: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus randomized traffic
// against a transaction-level model (outstanding/stale/held bookkeeping).
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  instr_fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .opcode(opcode),
    .rd(rd),
    .funct3(funct3),
    .rs1(rs1),
    .rs2(rs2),
    .funct7(funct7)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference model: one request in flight at most, possibly stale
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;
  logic        m_have;
  logic        m_out;
  logic        m_stale;

  task automatic tick();
    logic er;
    logic acc;
    logic rsp;
    er = !m_have && !m_out;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h13; m_inst_pc = 32'h0;
      m_have = 1'b0; m_out = 1'b0; m_stale = 1'b0;
    end else begin
      acc = er && imem_req_ready;
      rsp = m_out && imem_rsp_valid;
      if (m_have && (redirect_valid || !stall))
        m_have = 1'b0;
      if (rsp) begin
        if (!m_stale && !redirect_valid) begin
          m_inst = imem_rsp_data;
          m_inst_pc = m_pc;
          m_pc = m_pc + 32'd4;
          m_have = 1'b1;
        end
        m_out = 1'b0;
      end
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_out) m_stale = 1'b1;
      end
      if (acc) begin
        m_out = 1'b1;
        m_stale = redirect_valid;
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    m_have = 1'b0; m_out = 1'b0; m_stale = 1'b0;
    tick(); tick();
    rst = 1'b0;
    nvec++;
    if ({imem_req_valid, inst_valid} !== 2'b10) begin
      nerr++; $display("FAIL reset_ctl got %b want 10", {imem_req_valid, inst_valid});
    end
    nvec++;
    if (imem_addr !== 32'h0 || inst !== 32'h13 || inst_pc !== 32'h0) begin
      nerr++; $display("FAIL reset_regs got %h %h %h want 0 13 0", imem_addr, inst, inst_pc);
    end
  endtask

  task automatic test_run();
    int c0;
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    tick();
    c0 = cyc;
    nvec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || opcode !== 7'h13 || rd !== 5'd1) begin
      nerr++; $display("FAIL run_first got v=%b pc=%h op=%h rd=%0d want 1 0 13 1", inst_valid, inst_pc, opcode, rd);
    end
    tick(); tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8133;
    tick();
    nvec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || opcode !== 7'h33 || rd !== 5'd2) begin
      nerr++; $display("FAIL run_second got v=%b pc=%h op=%h rd=%0d want 1 4 33 2", inst_valid, inst_pc, opcode, rd);
    end
    nvec++;
    if (funct3 !== 3'd0 || funct7 !== 7'd0 || rs1 !== 5'd1 || rs2 !== 5'd2) begin
      nerr++; $display("FAIL run_fields got f3=%0d f7=%h rs1=%0d rs2=%0d want 0 0 1 2", funct3, funct7, rs1, rs2);
    end
    nvec++;
    if (cyc - c0 !== 3) begin
      nerr++; $display("FAIL run_spacing got %0d want 3", cyc - c0);
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4020_8133; stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (inst !== 32'h4020_8133 || funct7 !== 7'h20 || inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
        nerr++; $display("FAIL stall_hold[%0d] got inst=%h f7=%h v=%b req=%b want 40208133 20 1 0", i, inst, funct7, inst_valid, imem_req_valid);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC || inst_valid !== 1'b0) begin
      nerr++; $display("FAIL stall_release got req=%b addr=%h v=%b want 1 c 0", imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    nvec++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      nerr++; $display("FAIL redir_wait_drop got req=%b v=%b want 0 0", imem_req_valid, inst_valid);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      nerr++; $display("FAIL redir_wait_next got req=%b addr=%h v=%b want 1 100 0", imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_coincident();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_req_ready = 1'b0;
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
      nerr++; $display("FAIL redir_coinc got req=%b addr=%h v=%b want 1 200 0", imem_req_valid, imem_addr, inst_valid);
    end
    tick();
    nvec++;
    if (inst_valid !== 1'b0 || inst === 32'h1234_5678) begin
      nerr++; $display("FAIL redir_coinc_inst got v=%b inst=%h want 0 not 12345678", inst_valid, inst);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
        nerr++; $display("FAIL wrap_bp[%0d] got req=%b addr=%h want 1 fffffffc", i, imem_req_valid, imem_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    nvec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      nerr++; $display("FAIL wrap_cap got v=%b pc=%h want 1 fffffffc", inst_valid, inst_pc);
    end
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      nerr++; $display("FAIL wrap_next got req=%b addr=%h want 1 0", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0513; stall = 1'b1;
    tick();
    nvec++;
    if (inst_valid !== 1'b1 || inst !== 32'h00A0_0513) begin
      nerr++; $display("FAIL rstmid_hold got v=%b inst=%h want 1 00a00513", inst_valid, inst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    nvec++;
    if (inst_valid !== 1'b0 || inst !== 32'h13 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      nerr++; $display("FAIL rstmid got v=%b inst=%h req=%b addr=%h want 0 13 1 0", inst_valid, inst, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_random();
    int lat = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      stall = ($urandom_range(0, 9) < 4);
      imem_rsp_valid = 1'b0;
      if (m_out) begin
        if (lat == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = $urandom;
        end else begin
          lat--;
        end
      end else if (!m_have && imem_req_ready) begin
        lat = $urandom_range(0, 2);
      end
      tick();
      nvec++;
      if (imem_req_valid !== (!m_have && !m_out) || imem_addr !== m_pc) begin
        nerr++; $display("FAIL rand_req[%0d] got req=%b addr=%h want %b %h", i, imem_req_valid, imem_addr, !m_have && !m_out, m_pc);
      end
      nvec++;
      if (inst_valid !== m_have || inst !== m_inst || inst_pc !== m_inst_pc) begin
        nerr++; $display("FAIL rand_inst[%0d] got v=%b inst=%h pc=%h want %b %h %h", i, inst_valid, inst, inst_pc, m_have, m_inst, m_inst_pc);
      end
      nvec++;
      if ({funct7, rs2, rs1, funct3, rd, opcode} !== m_inst) begin
        nerr++; $display("FAIL rand_fields[%0d] got %h want %h", i, {funct7, rs2, rs1, funct3, rd, opcode}, m_inst);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Fetch stage directly upstream of the control unit. It holds the program counter and issues word requests to instruction memory over a valid/ready request channel, accepting data on a response channel. Each returned word is latched into an instruction register, which drives opcode/funct3/funct7 and register indices to the control unit and register file. It also supports stalls from downstream and PC redirects from branch/jump resolution, discarding any in-flight fetch that a redirect makes stale.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction register value after reset (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  32  fetch address; always equals the current pc.
imem_rsp_valid  input  1  response data valid. Exactly one response per accepted request, no earlier than the cycle after acceptance.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  load a new PC and flush the stage.
redirect_pc  input  32  redirect target. Bits [1:0] are ignored and forced to 0.
stall  input  1  downstream cannot consume the presented instruction.
inst  output  32  instruction register.
inst_pc  output  32  PC of inst.
inst_valid  output  1  inst is a live instruction for downstream.
opcode  output  7  inst[6:0].
rd  output  5  inst[11:7].
funct3  output  3  inst[14:12].
rs1  output  5  inst[19:15].
rs2  output  5  inst[24:20].
funct7  output  7  inst[31:25].

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=REQ, inst=NOP_INSTR, inst_pc=0, inst_valid=0. Reset overrides every other input and abandons any outstanding memory request; the memory side is reset with the same rst.
- Field outputs are pure combinational slices of inst and are meaningful only when inst_valid=1.
- imem_req_valid=1 only in REQ. imem_addr=pc in every state.
- State REQ:
  - redirect_valid=1 and imem_req_ready=0: pc<=redirect_pc, stay REQ.
  - redirect_valid=1 and imem_req_ready=1: pc<=redirect_pc, go to DROP, because the request was accepted and its response is stale.
  - imem_req_ready=1 with no redirect: go to WAIT.
  - Otherwise hold in REQ, keeping imem_req_valid and imem_addr stable.
- State WAIT:
  - imem_rsp_valid=1 with no redirect: inst<=imem_rsp_data, inst_pc<=pc, pc<=pc+4, inst_valid<=1, go to HOLD.
  - redirect_valid=1 and imem_rsp_valid=1: drop the data, pc<=redirect_pc, go to REQ.
  - redirect_valid=1 and imem_rsp_valid=0: pc<=redirect_pc, go to DROP.
- State DROP:
  - No request issued.
  - imem_rsp_valid=1: discard the data, go to REQ.
  - redirect_valid=1: pc<=redirect_pc (latest redirect wins). If a response also arrives that cycle, it is discarded and the next state is REQ.
- State HOLD:
  - inst_valid=1; inst, inst_pc and the field outputs are held stable.
  - redirect_valid=1: inst_valid<=0, pc<=redirect_pc, go to REQ. This applies regardless of stall.
  - stall=0: instruction consumed this cycle; inst_valid<=0, go to REQ.
  - stall=1: stay in HOLD, no new request.
- Latency: from a request accepted in cycle N with the response in N+1, inst_valid rises at the edge ending N+1. Best-case throughput is one instruction every 3 cycles (REQ, WAIT, HOLD).
- pc+4 wraps modulo 2^32: pc 32'hFFFF_FFFC becomes 32'h0000_0000.
- inst is not modified outside the WAIT-capture path and reset. After a flush it keeps its old contents with inst_valid=0.
- A response arriving in REQ or HOLD is a protocol violation. It is ignored and no state changes.

Test Plan:
- Reset then run: rst for 2 cycles, memory with ready=1 and one-cycle response returning 32'h00500093 at 0x0 and 32'h00208133 at 0x4.
  - inst_valid pulses with inst_pc=0x0, opcode=7'h13, rd=1; then with inst_pc=0x4, opcode=7'h33, funct3=0, funct7=0, rs1=1, rs2=2, rd=2.
  - 3-cycle spacing between instructions.
- Stall: hold stall=1 for 4 cycles while in HOLD with inst=32'h40208133.
  - inst, funct7=7'h20 and inst_valid=1 stay stable; imem_req_valid=0 throughout.
  - The next request (addr=pc+4) is issued the cycle after stall drops.
- Redirect in WAIT: request 0x8 accepted, redirect_pc=32'h0000_0103 asserted before the response.
  - Response for 0x8 is discarded; inst_valid stays 0.
  - Next request has addr=0x100.
- Redirect coincident with the response in WAIT: response dropped, next request addr=redirect target, and no inst_valid pulse for the old address.
- Backpressure and wrap: imem_req_ready=0 for 5 cycles at pc=32'hFFFF_FFFC.
  - imem_req_valid and imem_addr are held stable.
  - After the response, the next request addr=32'h0000_0000.
- Reset mid-operation: rst asserted in HOLD with stall=1.
  - Next cycle: inst_valid=0, inst=32'h00000013, imem_req_valid=1, imem_addr=RESET_PC.
